// File: rtl/ov2640_pkg.sv
// Shared defaults and RGB565 field layout for the OV2640 capture path.
package ov2640_pkg;

  localparam int MAX_PIXELS_DEF = 76800;
  localparam int ADDR_W_DEF     = 17;

  localparam int RGB_R_MSB = 15;
  localparam int RGB_R_LSB = 11;
  localparam int RGB_G_MSB = 10;
  localparam int RGB_G_LSB = 5;
  localparam int RGB_B_MSB = 4;
  localparam int RGB_B_LSB = 0;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  // Camera sends the high byte first; the pixel is simply {first, second}.
  function automatic rgb565_t rgb565_pack(input logic [7:0] hi, input logic [7:0] lo);
    return rgb565_t'({hi, lo});
  endfunction

endpackage

// File: rtl/ov2640_byte_pair.sv
// Pairs camera bytes into pixels: phase flag, high-byte latch and the
// combinational pair-valid pulse seen on the edge of the second byte.
module ov2640_byte_pair
  import ov2640_pkg::*;
(
  input  logic       i_pclk,
  input  logic       i_reset,
  input  logic       i_vsync,
  input  logic       i_href,
  input  logic [7:0] i_d,
  output logic       o_pair_valid,
  output logic [7:0] o_high_byte
);

  logic       r_phase;
  logic [7:0] r_high_byte;

  assign o_pair_valid = i_href & r_phase & ~i_vsync;
  assign o_high_byte  = r_high_byte;

  // Phase restarts on every blanking gap so a dangling odd byte is dropped.
  always_ff @(posedge i_pclk) begin
    if (i_reset) begin
      r_phase     <= 1'b0;
      r_high_byte <= 8'h00;
    end else if (i_vsync || !i_href) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~r_phase;
      if (!r_phase) begin
        r_high_byte <= i_d;
      end
    end
  end

endmodule

// File: rtl/ov_2640capture.sv
// OV2640 RGB565 capture: assembles byte pairs into pixels and writes them to
// contiguous frame-buffer addresses, restarting at address 0 on each vsync.
module ov_2640capture
  import ov2640_pkg::*;
#(
  parameter int MAX_PIXELS = MAX_PIXELS_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              vsync,
  input  logic              href,
  input  logic [7:0]        d,
  output logic [ADDR_W-1:0] addr,
  output logic [15:0]       dout,
  output logic              we
);

  // One extra bit so the counter can sit at MAX_PIXELS even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0] MAX_CNT = (ADDR_W+1)'(MAX_PIXELS);
  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  logic              w_pair_valid;
  logic [7:0]        w_high_byte;
  logic              w_accept;
  logic [ADDR_W:0]   r_pix_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_dout;
  logic              r_we;

  ov2640_byte_pair u_byte_pair (
    .i_pclk       (pclk),
    .i_reset      (reset),
    .i_vsync      (vsync),
    .i_href       (href),
    .i_d          (d),
    .o_pair_valid (w_pair_valid),
    .o_high_byte  (w_high_byte)
  );

  assign w_accept = w_pair_valid && (r_pix_cnt < MAX_CNT);

  // Write strobe, address and pixel register; pairs past MAX_PIXELS are dropped.
  always_ff @(posedge pclk) begin
    if (reset) begin
      r_pix_cnt <= '0;
      r_addr    <= '0;
      r_dout    <= 16'h0000;
      r_we      <= 1'b0;
    end else if (vsync) begin
      r_pix_cnt <= '0;
      r_we      <= 1'b0;
    end else if (w_accept) begin
      r_dout    <= rgb565_pack(w_high_byte, d);
      r_addr    <= r_pix_cnt[ADDR_W-1:0];
      r_we      <= 1'b1;
      r_pix_cnt <= r_pix_cnt + CNT_ONE;
    end else begin
      r_we      <= 1'b0;
    end
  end

  assign addr = r_addr;
  assign dout = r_dout;
  assign we   = r_we;

endmodule

// File: tb/tb_ov_2640capture.sv
// Directed bench for ov_2640capture: a default-size instance and a
// MAX_PIXELS=4 instance share the same camera stimulus.
module tb_ov_2640capture;

  logic        clk;
  logic        reset;
  logic        vsync;
  logic        href;
  logic [7:0]  d;
  logic [16:0] a_addr;
  logic [15:0] a_dout;
  logic        a_we;
  logic [2:0]  b_addr;
  logic [15:0] b_dout;
  logic        b_we;

  int n_total;
  int n_bad;

  ov_2640capture dut_a (
    .pclk(clk), .reset(reset), .vsync(vsync), .href(href), .d(d),
    .addr(a_addr), .dout(a_dout), .we(a_we)
  );

  ov_2640capture #(.MAX_PIXELS(4), .ADDR_W(3)) dut_b (
    .pclk(clk), .reset(reset), .vsync(vsync), .href(href), .d(d),
    .addr(b_addr), .dout(b_dout), .we(b_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then sample just after the rising edge.
  task automatic cyc(input logic rs, input logic vs, input logic hr, input logic [7:0] dd);
    @(negedge clk);
    reset = rs;
    vsync = vs;
    href  = hr;
    d     = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_wr(input string tag, input logic [16:0] ea, input logic [15:0] ed);
    chk({tag, "_we"}, {31'd0, a_we}, 32'd1);
    chk({tag, "_addr"}, {15'd0, a_addr}, {15'd0, ea});
    chk({tag, "_dout"}, {16'd0, a_dout}, {16'd0, ed});
  endtask

  initial begin
    int k;
    int n_wr;
    int errs;
    logic [7:0] prev_d;
    logic [7:0] bd;
    n_total = 0;
    n_bad   = 0;
    reset = 1'b1; vsync = 1'b0; href = 1'b0; d = 8'h00;

    // Reset state
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b1, 8'hFF);
    chk("rst_we",   {31'd0, a_we}, 32'd0);
    chk("rst_addr", {15'd0, a_addr}, 32'd0);
    chk("rst_dout", {16'd0, a_dout}, 32'd0);
    chk("rst_b_we", {31'd0, b_we}, 32'd0);

    // Basic two-pixel line
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h12);
    chk("s1_b0_we", {31'd0, a_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h34);
    chk_a_wr("s1_p0", 17'd0, 16'h1234);
    cyc(1'b0, 1'b0, 1'b1, 8'h56);
    chk("s1_b2_we", {31'd0, a_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h78);
    chk_a_wr("s1_p1", 17'd1, 16'h5678);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s1_end_we", {31'd0, a_we}, 32'd0);
    chk("s1_hold_dout", {16'd0, a_dout}, 32'h5678);

    // Odd-length line drops its dangling byte
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'hAA);
    cyc(1'b0, 1'b0, 1'b1, 8'hBB);
    chk_a_wr("s2_p0", 17'd0, 16'hAABB);
    cyc(1'b0, 1'b0, 1'b1, 8'hCC);
    chk("s2_cc_we", {31'd0, a_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s2_gap_we", {31'd0, a_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h11);
    chk("s2_11_we", {31'd0, a_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h22);
    chk_a_wr("s2_p1", 17'd1, 16'h1122);

    // vsync mid-line wins over href and restarts addressing
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h01);
    cyc(1'b0, 1'b0, 1'b1, 8'h02);
    chk_a_wr("s3_p0", 17'd0, 16'h0102);
    cyc(1'b0, 1'b0, 1'b1, 8'h03);
    cyc(1'b0, 1'b1, 1'b1, 8'h04);
    chk("s3_vs_we", {31'd0, a_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h05);
    chk("s3_05_we", {31'd0, a_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h06);
    chk_a_wr("s3_p1", 17'd0, 16'h0506);

    // Reset at phase 1 mid-line
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h10);
    cyc(1'b0, 1'b0, 1'b1, 8'h20);
    chk_a_wr("s4_p0", 17'd0, 16'h1020);
    cyc(1'b0, 1'b0, 1'b1, 8'h30);
    cyc(1'b1, 1'b0, 1'b1, 8'h40);
    chk("s4_rst_we",   {31'd0, a_we}, 32'd0);
    chk("s4_rst_dout", {16'd0, a_dout}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h50);
    chk("s4_50_we", {31'd0, a_we}, 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 8'h60);
    chk_a_wr("s4_p1", 17'd0, 16'h5060);

    // Saturation on the MAX_PIXELS=4 instance
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      bd = 8'hC0 + 8'(i);
      cyc(1'b0, 1'b0, 1'b1, bd);
      if ((i % 2) == 0) begin
        chk($sformatf("s5_b%0d_we", i), {31'd0, b_we}, 32'd0);
      end else if ((i / 2) < 4) begin
        chk($sformatf("s5_p%0d_we", i / 2), {31'd0, b_we}, 32'd1);
        chk($sformatf("s5_p%0d_addr", i / 2), {29'd0, b_addr}, 32'(i / 2));
        chk($sformatf("s5_p%0d_dout", i / 2), {16'd0, b_dout}, {16'd0, bd - 8'd1, bd});
      end else begin
        chk($sformatf("s5_p%0d_drop", i / 2), {31'd0, b_we}, 32'd0);
      end
    end
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    chk("s5_hold_addr", {29'd0, b_addr}, 32'd3);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h9A);
    cyc(1'b0, 1'b0, 1'b1, 8'hBC);
    chk("s5_re_we",   {31'd0, b_we}, 32'd1);
    chk("s5_re_addr", {29'd0, b_addr}, 32'd0);
    chk("s5_re_dout", {16'd0, b_dout}, 32'h9ABC);

    // Full 24-line run with incrementing data
    cyc(1'b0, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00);
    k = 0; n_wr = 0; errs = 0; prev_d = 8'h00;
    for (int ln = 0; ln < 24; ln++) begin
      for (int c = 0; c < 1920; c++) begin
        cyc(1'b0, 1'b0, (c < 1600) ? 1'b1 : 1'b0, 8'(k));
        if (a_we) begin
          if (c >= 1600 || (c % 2) == 0) errs++;
          if (a_addr != 17'(n_wr)) errs++;
          if (a_dout != {prev_d, 8'(k)}) errs++;
          if (prev_d[0] != 1'b0) errs++;
          n_wr++;
        end else if (c < 1600 && (c % 2) == 1) begin
          errs++;
        end
        prev_d = 8'(k);
        k++;
      end
    end
    chk("s6_writes", 32'(n_wr), 32'd19200);
    chk("s6_errs",   32'(errs), 32'd0);
    chk("s6_last_addr", {15'd0, a_addr}, 32'd19199);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ov_2640capture.md
OV_2640CAPTURE -- requirements
Module: ov_2640capture

Interface
- REQ-001 Parameter MAX_PIXELS, default 76800 (320x240): number of pixel writes accepted per frame.
- REQ-002 Parameter ADDR_W, default 17: width of addr; SHALL satisfy 2**ADDR_W >= MAX_PIXELS.
- REQ-003 pclk, input, 1: camera pixel clock; the only clock; all logic on rising edge.
- REQ-004 reset, input, 1: synchronous, active-high reset.
- REQ-005 vsync, input, 1: frame sync; high = vertical blanking / frame restart.
- REQ-006 href, input, 1: line valid; high = d carries pixel bytes.
- REQ-007 d, input, 8: camera data byte, RGB565, high byte first.
- REQ-008 addr, output, ADDR_W: frame-buffer write address, valid while we=1.
- REQ-009 dout, output, 16: assembled RGB565 pixel {first byte, second byte}.
- REQ-010 we, output, 1: one-cycle write strobe for addr/dout.

Function
- REQ-011 The block SHALL sample vsync, href and d directly on each rising pclk edge, with no input resynchronization, because it runs in the camera clock domain.
- REQ-012 Byte phase flag: cleared while href=0; toggles each cycle href=1; phase 0 byte is latched as high byte.
- REQ-013 On an edge with href=1, phase=1, vsync=0 and pix_cnt<MAX_PIXELS, the block SHALL register the following on that same edge:
  - dout <= {high_byte, d}
  - addr <= pix_cnt
  - we <= 1
  - pix_cnt <= pix_cnt+1
- REQ-014 On every other edge, we SHALL be 0; addr and dout hold their last values.
- REQ-015 Latency: the second byte is sampled at edge N; we, addr and dout are valid from edge N until edge N+1.
- REQ-016 While vsync=1, the block SHALL do all of the following:
  - pix_cnt <= 0
  - phase <= 0
  - we <= 0
  - href ignored
- REQ-017 When vsync=1 and href=1 on the same edge, vsync SHALL win: no write occurs.
- REQ-018 href falling after an odd number of bytes SHALL discard the dangling byte; the next line restarts at phase 0.
- REQ-019 pix_cnt SHALL stop incrementing at MAX_PIXELS; further pixel pairs are dropped (we=0) until the next vsync; addr never exceeds MAX_PIXELS-1.
- REQ-020 Addresses SHALL be contiguous across lines; the line structure is not encoded in addr.
- REQ-021 Odd/even pairing SHALL depend only on phase, not on byte values.

Reset
- REQ-022 With reset=1 at a rising edge, the following SHALL all be cleared to 0:
  - addr
  - dout
  - we
  - pix_cnt
  - phase
  - high_byte
- REQ-023 Reset SHALL take priority over vsync and href.
- REQ-024 Reset mid-line or mid-frame SHALL abandon the current pixel, and capture resumes at address 0.

Structure
- REQ-025 Package ov2640_pkg SHALL hold the MAX_PIXELS/ADDR_W defaults and the RGB565 field positions:
  - R [15:11]
  - G [10:5]
  - B [4:0]
- REQ-026 A single sub-module, ov2640_byte_pair (phase flag + high-byte latch + pair-valid pulse), is natural; the address counter stays in the top.
- REQ-027 The design SHALL be purely synchronous, with no latches and no gated clocks.

Verification
- REQ-028 Scenario: reset, vsync pulse, then href high 4 cycles with d=0x12,0x34,0x56,0x78 -> writes (addr 0, dout 0x1234) and (addr 1, dout 0x5678); each we is one cycle wide.
- REQ-029 Scenario: line 1 of 3 bytes (0xAA,0xBB,0xCC), href low, line 2 of 2 bytes (0x11,0x22) -> exactly two writes: 0xAABB@0 and 0x1122@1; 0xCC is dropped.
- REQ-030 Scenario: d incrementing every cycle, 24 lines of 1600-cycle href separated by 320-cycle gaps -> 19200 writes, addr 0..19199 contiguous, each dout = {k, k+1} with even k (mod 256).
- REQ-031 Scenario: vsync asserted mid-line -> we drops immediately; after vsync falls, the next pair writes to addr 0.
- REQ-032 Scenario: MAX_PIXELS=4, href for 12 bytes -> writes only at addr 0..3, then we stays 0 until vsync.
- REQ-033 Scenario: reset asserted at phase 1 mid-line -> no write that cycle; all outputs 0 next cycle; capture resumes at addr 0 with phase 0.
